sync_gray_ptr: RTL

//   Parametrised N-stage synchroniser for a Gray-coded FIFO pointer arriving from a foreign clock domain.

---
 rtl/sync_gray_ptr.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sync_gray_ptr.sv
// Multi-stage synchroniser for a Gray-coded FIFO pointer crossing into the CLK domain.
// Adds a registered binary view, a change strobe and a Gray-step integrity checker.
module sync_gray_ptr #(
    parameter int ADDR_SIZE   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CHECK_GRAY  = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [ADDR_SIZE:0]   PTR_GRAY,
    input  logic                 ERR_CLR,
    output logic [ADDR_SIZE:0]   Q_GRAY,
    output logic [ADDR_SIZE:0]   Q_BIN,
    output logic                 CHANGE,
    output logic                 GRAY_ERR,
    output logic [7:0]           ERR_CNT
);

    localparam int W = ADDR_SIZE + 1;

    if (SYNC_STAGES < 2) begin : g_stage_check
        $error("sync_gray_ptr: SYNC_STAGES must be at least 2");
    end

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [7:0] popcount(input logic [W-1:0] v);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < W; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] prev_q;
    logic [W-1:0] q_bin_q,    q_bin_d;
    logic         change_q,   change_d;
    logic         gray_err_q, gray_err_d;
    logic [7:0]   err_cnt_q,  err_cnt_d;

    logic [W-1:0] last_s;
    logic [7:0]   dist_s;
    logic [7:0]   cnt_base_s;

    assign last_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: plain flop-to-flop, nothing in between stages.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= {W{1'b0}};
            end
        end else begin
            sync_q[0] <= PTR_GRAY;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Step classification and next-state for the binary view and error bookkeeping.
    always_comb begin
        dist_s     = popcount(last_s ^ prev_q);
        q_bin_d    = q_bin_q;
        change_d   = 1'b0;
        gray_err_d = gray_err_q;
        err_cnt_d  = err_cnt_q;
        cnt_base_s = err_cnt_q;
        if (CHECK_GRAY != 0) begin
            if (dist_s == 8'd1) begin
                q_bin_d  = gray2bin(last_s);
                change_d = 1'b1;
            end else begin
                q_bin_d  = q_bin_q;
                change_d = 1'b0;
            end
            if (ERR_CLR) begin
                cnt_base_s = 8'd0;
                gray_err_d = 1'b0;
            end else begin
                cnt_base_s = err_cnt_q;
                gray_err_d = gray_err_q;
            end
            // A violation on the same edge as a clear still gets recorded.
            if (dist_s >= 8'd2) begin
                gray_err_d = 1'b1;
                err_cnt_d  = (cnt_base_s == 8'hFF) ? 8'hFF : cnt_base_s + 8'd1;
            end else begin
                err_cnt_d  = cnt_base_s;
            end
        end else begin
            if (dist_s != 8'd0) begin
                q_bin_d  = gray2bin(last_s);
                change_d = 1'b1;
            end else begin
                q_bin_d  = q_bin_q;
                change_d = 1'b0;
            end
            gray_err_d = 1'b0;
            err_cnt_d  = 8'd0;
        end
    end

    // Output and checker state registers; prev tracks the last stage unconditionally.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_q     <= {W{1'b0}};
            q_bin_q    <= {W{1'b0}};
            change_q   <= 1'b0;
            gray_err_q <= 1'b0;
            err_cnt_q  <= 8'd0;
        end else begin
            prev_q     <= last_s;
            q_bin_q    <= q_bin_d;
            change_q   <= change_d;
            gray_err_q <= gray_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign Q_GRAY   = last_s;
    assign Q_BIN    = q_bin_q;
    assign CHANGE   = change_q;
    assign GRAY_ERR = gray_err_q;
    assign ERR_CNT  = err_cnt_q;

endmodule
